// File: rtl/modn_ctrl.sv
// Modulo-N run controller: counts 0..N-1 for a configured number of laps with pause/abort control.
// Optional MODN_CTRL_AUTORELOAD_EN: the final wrap pulses done, clears lap and keeps running.
module modn_ctrl #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned LAPW    = 4,
    parameter int unsigned DEF_MOD = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic [LAPW-1:0]  cfg_laps,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [LAPW-1:0]  lap,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [LAPW-1:0] LAP_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [LAPW-1:0]  lap_q, lap_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [LAPW-1:0]  laps_q, laps_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             xfer;
    logic             cfg_ok;
    logic             at_wrap;
    logic [LAPW-1:0]  lap_inc;

    assign xfer    = cfg_valid & cfg_ready_q;
    assign cfg_ok  = (cfg_mod >= WIDTH'(2));
    assign at_wrap = (count_q == (mod_q - WIDTH'(1)));
    assign lap_inc = (lap_q == LAP_MAX) ? lap_q : (lap_q + LAPW'(1));

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lap_d       = lap_q;
        mod_d       = mod_q;
        laps_d      = laps_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        tc_d        = 1'b0;
        busy_d      = 1'b0;
        cfg_ready_d = 1'b1;

        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
            lap_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (xfer) begin
                        if (cfg_ok) begin
                            mod_d  = cfg_mod;
                            laps_d = cfg_laps;
                            if (state_q == S_DONE) begin
                                state_d = S_IDLE;
                                count_d = '0;
                                lap_d   = '0;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // pause outranks start, so a paused start is simply not taken
                    if (start && !pause) begin
                        state_d = S_RUN;
                        count_d = '0;
                        lap_d   = '0;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                        if (at_wrap) begin
                            count_d = '0;
                            if ((laps_q != '0) && (lap_inc == laps_q)) begin
                                done_d = 1'b1;
`ifdef MODN_CTRL_AUTORELOAD_EN
                                lap_d   = '0;
`else
                                lap_d   = laps_q;
                                state_d = S_DONE;
`endif
                            end else begin
                                lap_d = lap_inc;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                    lap_d   = '0;
                end
            endcase
        end

        busy_d      = (state_d == S_RUN) || (state_d == S_PAUSE);
        cfg_ready_d = !busy_d;
        tc_d        = busy_d && (count_d == (mod_d - WIDTH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            lap_q       <= '0;
            mod_q       <= WIDTH'(DEF_MOD);
            laps_q      <= LAPW'(1);
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lap_q       <= lap_d;
            mod_q       <= mod_d;
            laps_q      <= laps_d;
            tc_q        <= tc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign count     = count_q;
    assign lap       = lap_q;
    assign tc        = tc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_modn_ctrl.sv
// Scoreboard bench for modn_ctrl: a behavioural model predicts each cycle's outputs into a queue,
// a monitor on the falling edge pops and compares.
module tb_modn_ctrl;

    localparam int unsigned WIDTH   = 3;
    localparam int unsigned LAPW    = 4;
    localparam int unsigned DEF_MOD = 5;
    localparam int          LAP_TOP = (1 << LAPW) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_mod = '0;
    logic [LAPW-1:0]  cfg_laps = '0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic [LAPW-1:0]  lap;
    logic             busy;
    logic             done;
    logic             err;

    modn_ctrl #(.WIDTH(WIDTH), .LAPW(LAPW), .DEF_MOD(DEF_MOD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mod(cfg_mod), .cfg_laps(cfg_laps),
        .start(start), .pause(pause), .abort(abort),
        .count(count), .tc(tc), .lap(lap),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int cyc;
        int count;
        int lap;
        bit tc;
        bit busy;
        bit done;
        bit err;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: a run is either absent, active (possibly held) or finished
    int m_mod, m_laps, m_cnt, m_lap;
    bit m_active, m_held, m_fin;

    function automatic void model_reset();
        m_mod = DEF_MOD; m_laps = 1; m_cnt = 0; m_lap = 0;
        m_active = 0; m_held = 0; m_fin = 0;
    endfunction

    function automatic exp_t model_step(bit st, bit pa, bit ab, bit cv, int cm, int cl);
        exp_t e;
        e.done = 0;
        e.err  = 0;
        if (ab) begin
            m_active = 0; m_held = 0; m_fin = 0; m_cnt = 0; m_lap = 0;
        end else if (!m_active) begin
            if (cv) begin
                if (cm >= 2) begin
                    m_mod = cm; m_laps = cl;
                    if (m_fin) begin m_fin = 0; m_cnt = 0; m_lap = 0; end
                end else begin
                    e.err = 1;
                end
            end
            if (st && !pa) begin
                m_active = 1; m_held = 0; m_fin = 0; m_cnt = 0; m_lap = 0;
            end
        end else if (pa) begin
            m_held = 1;
        end else begin
            m_held = 0;
            m_cnt  = (m_cnt + 1) % m_mod;
            if (m_cnt == 0) begin
                m_lap = (m_lap + 1 > LAP_TOP) ? LAP_TOP : m_lap + 1;
                if (m_laps != 0 && m_lap == m_laps) begin
                    e.done = 1;
`ifdef MODN_CTRL_AUTORELOAD_EN
                    m_lap = 0;
`else
                    m_active = 0; m_fin = 1;
`endif
                end
            end
        end
        e.count = m_cnt;
        e.lap   = m_lap;
        e.busy  = m_active;
        e.rdy   = !m_active;
        e.tc    = m_active && (m_cnt == m_mod - 1);
        return e;
    endfunction

    // One cycle of stimulus; reset is asynchronous so its expectation is due this very cycle
    task automatic drive(bit rn, bit st, bit pa, bit ab, bit cv, int cm, int cl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; start = st; pause = pa; abort = ab;
        cfg_valid = cv; cfg_mod = WIDTH'(cm); cfg_laps = LAPW'(cl);
        if (!rn) begin
            model_reset();
            exp_q.delete();
            e = '{cyc: cyc_cnt, count: 0, lap: 0, tc: 0, busy: 0, done: 0, err: 0, rdy: 1};
        end else begin
            e = model_step(st, pa, ab, cv, cm, cl);
            e.cyc = cyc_cnt + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every prediction whose cycle has arrived
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (count !== WIDTH'(e.count) || lap !== LAPW'(e.lap) || tc !== e.tc ||
                busy !== e.busy || done !== e.done || err !== e.err || cfg_ready !== e.rdy) begin
                errors++;
                $display("FAIL outputs cyc%0d: got count=%0d lap=%0d tc=%b busy=%b done=%b err=%b rdy=%b, expected count=%0d lap=%0d tc=%b busy=%b done=%b err=%b rdy=%b",
                         e.cyc, count, lap, tc, busy, done, err, cfg_ready,
                         e.count, e.lap, e.tc, e.busy, e.done, e.err, e.rdy);
            end
        end
    end

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // default mod 5, one lap
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(8);
        // illegal modulus is rejected, run still counts mod 5
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 3);
        drive(1, 0, 0, 0, 1, 0, 2);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(7);
        // pause three cycles at count 2
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        idle(4);
        // abort together with pause at count 3
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(3);
        drive(1, 0, 1, 1, 0, 0, 0);
        idle(2);
        // mod 3, two laps
        drive(1, 0, 0, 0, 1, 3, 2);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(9);
        // mid-run reset discards the run
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // free-running lap saturation
        drive(1, 0, 0, 0, 1, 2, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(40);
        drive(1, 0, 0, 1, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit rn, st, pa, ab, cv;
            rn = ($urandom_range(0, 499) != 0);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 59) == 0);
            cv = ($urandom_range(0, 5) == 0);
            drive(rn, st, pa, ab, cv, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end
        idle(3);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modn_ctrl.md
MODN_CTRL -- requirements
Module: modn_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, count register width.
REQ-002 SHALL have parameter LAPW, default 4, lap counter width.
REQ-003 SHALL have parameter DEF_MOD, default 5, modulus loaded at reset.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  config offer.
REQ-007 SHALL have port cfg_ready  output  1  config acceptance.
REQ-008 SHALL have port cfg_mod  input  WIDTH  requested modulus N.
REQ-009 SHALL have port cfg_laps  input  LAPW  requested lap count; 0 = run until abort.
REQ-010 SHALL have port start  input  1  begin counting.
REQ-011 SHALL have port pause  input  1  hold count while high.
REQ-012 SHALL have port abort  input  1  stop and clear.
REQ-013 SHALL have port count  output  WIDTH  current count value.
REQ-014 SHALL have port tc  output  1  terminal-count flag.
REQ-015 SHALL have port lap  output  LAPW  completed laps in current run.
REQ-016 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-017 SHALL have port done  output  1  one-cycle run-complete pulse.
REQ-018 SHALL have port err  output  1  one-cycle illegal-config pulse.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-020 SHALL drive cfg_ready high only in IDLE and DONE; transfer = cfg_valid & cfg_ready at rising clk.
REQ-021 SHALL store cfg_mod/cfg_laps on transfer when 2 <= cfg_mod <= 2^WIDTH-1; accepted transfer in DONE moves FSM to IDLE.
REQ-022 SHALL, on transfer with cfg_mod of 0 or 1, keep stored config and pulse err for exactly one cycle.
REQ-023 SHALL, on start in IDLE or DONE, enter RUN with count=0 and lap=0 next cycle; start is ignored in RUN/PAUSE.
REQ-024 SHALL, in RUN, increment count by 1 per cycle, wrapping from N-1 to 0.
REQ-025 SHALL assert tc in every cycle in which count equals N-1 while in RUN or PAUSE.
REQ-026 SHALL increment lap on every wrap, saturating at 2^LAPW-1 when stored laps = 0.
REQ-027 SHALL, when stored laps != 0 and the wrap completes lap number laps, pulse done and enter DONE with count=0 and lap holding laps.
REQ-028 SHALL move RUN->PAUSE while pause is high and PAUSE->RUN when pause low; count and lap frozen in PAUSE.
REQ-029 SHALL, on abort in any state, enter IDLE next cycle with count=0, lap=0, no done pulse; stored config unchanged.
REQ-030 SHALL give priority abort > pause > start/counting on simultaneous assertion.
REQ-031 SHALL, when pause is high on the final wrap cycle, not perform the wrap until pause releases.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force IDLE, count=0, lap=0, tc=0, busy=0, done=0, err=0, cfg_ready=1, stored mod=DEF_MOD, stored laps=1.
REQ-033 SHALL resume operation on the first rising clk after rst_n deasserts; reset mid-run discards the run.

Configuration
REQ-034 SHALL honour macro MODN_CTRL_AUTORELOAD_EN: when defined, the final wrap pulses done, clears lap to 0 and stays in RUN (DONE never entered) until abort; when undefined, REQ-027 applies.

Verification
REQ-035 SHALL cover: reset, start, default mod 5, laps 1 -> count 0,1,2,3,4, tc at count 4, done one cycle after count 4, state DONE, lap=1.
REQ-036 SHALL cover: cfg_mod=3, cfg_laps=2, start -> count 0,1,2,0,1,2,0; two tc pulses; done after second wrap; lap=2.
REQ-037 SHALL cover: cfg_mod=1 offered in IDLE -> err one cycle; subsequent run still counts mod 5.
REQ-038 SHALL cover: pause high 3 cycles at count=2 -> count holds 2 for 3 cycles, busy stays 1, then continues 3,4.
REQ-039 SHALL cover: abort and pause both high at count=3 -> next cycle IDLE, count=0, lap=0, busy=0, no done.
REQ-040 SHALL cover: MODN_CTRL_AUTORELOAD_EN defined, mod 5, laps 1 -> done pulse every 5 cycles, busy stays 1, cfg_ready stays 0.
